// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory block arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Grant selection between icache and dcache requests.
// With ARB_RR_EN defined, ties go to the client that did not win last time.
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = i_req | d_req;

`ifdef ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= GNT_I;
    else if (grant_en && grant_valid)
      last_grant <= grant_id;
  end

  always_comb begin
    grant_id = GNT_I;
    if (i_req && d_req)
      grant_id = (last_grant == GNT_I) ? GNT_D : GNT_I;
    else if (d_req)
      grant_id = GNT_D;
  end
`else
  logic unused_rr;
  assign unused_rr = clk ^ reset ^ grant_en;

  always_comb begin
    grant_id = GNT_I;
    if (d_req)
      grant_id = GNT_D;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises icache refills and dcache refills/writebacks onto one memory port.
// Optional round-robin tie-break: ARB_RR_EN. States:
//   IDLE    | waiting for a request
//   SERVE_I | icache read in flight on memory
//   SERVE_D | dcache read or write in flight on memory
//   DONE_I  | icache released for one cycle, no new grant
//   DONE_D  | dcache released for one cycle, no new grant
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  state_t               state, state_n;
  logic                 mem_read_n, mem_write_n;
  logic [ADDR_W-1:0]    mem_address_n;
  logic [BLOCK_W-1:0]   mem_writedata_n, i_readdata_n, d_readdata_n;
  logic                 grant_valid, grant_id;

  arb_grant_sel u_grant_sel (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .grant_en   (state == IDLE),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    state_n         = state;
    mem_read_n      = mem_read;
    mem_write_n     = mem_write;
    mem_address_n   = mem_address;
    mem_writedata_n = mem_writedata;
    i_readdata_n    = i_readdata;
    d_readdata_n    = d_readdata;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          if (grant_id == GNT_D) begin
            state_n         = SERVE_D;
            mem_address_n   = d_address;
            mem_writedata_n = d_writedata;
            // read+write together is illegal; the write wins
            mem_read_n      = d_read & ~d_write;
            mem_write_n     = d_write;
          end else begin
            state_n       = SERVE_I;
            mem_address_n = i_address;
            mem_read_n    = 1'b1;
            mem_write_n   = 1'b0;
          end
        end
      end
      SERVE_I: begin
        if (!mem_busywait) begin
          state_n      = DONE_I;
          mem_read_n   = 1'b0;
          mem_write_n  = 1'b0;
          i_readdata_n = mem_readdata;
        end
      end
      SERVE_D: begin
        if (!mem_busywait) begin
          state_n     = DONE_D;
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
          if (mem_read)
            d_readdata_n = mem_readdata;
        end
      end
      DONE_I, DONE_D: state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      state         <= state_n;
      mem_read      <= mem_read_n;
      mem_write     <= mem_write_n;
      mem_address   <= mem_address_n;
      mem_writedata <= mem_writedata_n;
      i_readdata    <= i_readdata_n;
      d_readdata    <= d_readdata_n;
    end
  end

  assign i_busywait = i_read & (state != DONE_I);
  assign d_busywait = (d_read | d_write) & (state != DONE_D);

endmodule
